// File: rtl/decoder38_seq.sv
// Registered 3-to-8 one-hot decoder with timed single-shot hold and a free-running scan mode.
// Define DECODER38_ACTIVE_LOW_EN for 74138-style active-low outputs (idle 8'hFF).
module decoder38_seq #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned SCAN_DIV    = 8
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEn,
    input  logic       iScan,
    input  logic       iValid,
    input  logic [2:0] iData,
    output logic       oReady,
    output logic [7:0] oData,
    output logic       oBusy,
    output logic       oDone
);

`ifdef DECODER38_ACTIVE_LOW_EN
    localparam logic [7:0] OutMask = 8'hFF;
`else
    localparam logic [7:0] OutMask = 8'h00;
`endif

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] ScanLoad = 8'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StIdle, StHold, StScan} state_e;

    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;   // active-high one-hot, polarity applied on the way out
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] scan_div_q, scan_div_d;
    logic [2:0] scan_idx_q, scan_idx_d;
    logic [2:0] scan_idx_inc;

    assign scan_idx_inc = scan_idx_q + 3'd1;
    assign oReady       = (state_q == StIdle) && iEn && !iScan;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (iEn && iScan) begin
                    state_d = StScan;
                end else if (iEn && iValid) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!iEn || hold_cnt_q == 8'd0) begin
                    state_d = StIdle;
                end
            end
            StScan: begin
                if (!iEn || !iScan) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d     = 8'h00;
        done_d     = 1'b0;
        hold_cnt_d = 8'd0;
        scan_div_d = 8'd0;
        scan_idx_d = 3'd0;
        busy_d     = (state_d == StHold) || (state_d == StScan);
        unique case (state_q)
            StIdle: begin
                if (iEn && iScan) begin
                    data_d     = 8'h01;
                    scan_div_d = ScanLoad;
                end else if (iEn && iValid) begin
                    data_d     = 8'd1 << iData;
                    hold_cnt_d = HoldLoad;
                end
            end
            StHold: begin
                // Abort takes priority over completion, so no done pulse on abort.
                if (iEn && hold_cnt_q == 8'd0) begin
                    done_d = 1'b1;
                end else if (iEn) begin
                    data_d     = data_q;
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            StScan: begin
                if (iEn && iScan) begin
                    if (scan_div_q == 8'd0) begin
                        scan_idx_d = scan_idx_inc;
                        data_d     = 8'd1 << scan_idx_inc;
                        scan_div_d = ScanLoad;
                    end else begin
                        scan_idx_d = scan_idx_q;
                        data_d     = data_q;
                        scan_div_d = scan_div_q - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            data_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_cnt_q <= 8'd0;
            scan_div_q <= 8'd0;
            scan_idx_q <= 3'd0;
        end else begin
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hold_cnt_q <= hold_cnt_d;
            scan_div_q <= scan_div_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign oData = data_q ^ OutMask;
    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_decoder38_seq.sv
// Directed self-checking bench for decoder38_seq (HOLD_CYCLES=4, SCAN_DIV=2).
// Honours DECODER38_ACTIVE_LOW_EN by inverting the expected output values.
module tb_decoder38_seq;

`ifdef DECODER38_ACTIVE_LOW_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       scan = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] din = 3'd0;
    logic       ready;
    logic [7:0] dout;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    decoder38_seq #(
        .HOLD_CYCLES(4),
        .SCAN_DIV   (2)
    ) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .iEn   (en),
        .iScan (scan),
        .iValid(valid),
        .iData (din),
        .oReady(ready),
        .oData (dout),
        .oBusy (busy),
        .oDone (done)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (dout !== INV) begin
            failures++;
            $display("FAIL reset_data got=%h exp=%h", dout, INV);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done);
        end
        step();
        rst_n = 1'b1;
        step();
        en = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", ready);
        end
    endtask

    task automatic test_single();
        valid = 1'b1;
        din   = 3'd5;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready_idle got=%b exp=1", ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            valid = 1'b0;
            din   = 3'bxxx;
            #1;
            checks++;
            if (dout !== (8'h20 ^ INV) || busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
                failures++;
                $display("FAIL single_hold cyc%0d got data=%h busy=%b done=%b ready=%b exp %h 1 0 0",
                         i, dout, busy, done, ready, 8'h20 ^ INV);
            end
        end
        step();
        checks++;
        if (dout !== INV || done !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL single_done got data=%h done=%b busy=%b ready=%b exp %h 1 0 1",
                     dout, done, busy, ready, INV);
        end
        step();
        checks++;
        if (done !== 1'b0 || dout !== INV) begin
            failures++;
            $display("FAIL single_done_pulse got done=%b data=%h exp 0 %h", done, dout, INV);
        end
        din = 3'd0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [10];
        logic       exp_done [10];
        for (int i = 0; i < 10; i++) begin
            exp_seq[i]  = (i < 4) ? 8'h01 : (i == 4) ? 8'h00 : (i < 9) ? 8'h80 : 8'h00;
            exp_done[i] = (i == 4) || (i == 9);
        end
        valid = 1'b1;
        din   = 3'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            din = 3'd7;
            if (i >= 4) valid = 1'b0;
            if (i == 4) valid = 1'b1;
            #1;
            checks++;
            if (dout !== (exp_seq[i] ^ INV) || done !== exp_done[i]) begin
                failures++;
                $display("FAIL b2b cyc%0d got data=%h done=%b exp %h %b",
                         i, dout, done, exp_seq[i] ^ INV, exp_done[i]);
            end
        end
        valid = 1'b0;
        step();
    endtask

    task automatic test_scan();
        logic [7:0] exp;
        scan = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            exp = 8'd1 << ((k / 2) % 8);
            checks++;
            if (dout !== (exp ^ INV) || busy !== 1'b1 || ready !== 1'b0) begin
                failures++;
                $display("FAIL scan_seq cyc%0d got data=%h busy=%b ready=%b exp %h 1 0",
                         k, dout, busy, ready, exp ^ INV);
            end
        end
        scan = 1'b0;
        step();
        checks++;
        if (dout !== INV || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL scan_stop got data=%h busy=%b done=%b exp %h 0 0", dout, busy, done, INV);
        end
    endtask

    task automatic test_scan_priority();
        scan  = 1'b1;
        valid = 1'b1;
        din   = 3'd3;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL prio_ready got=%b exp=0", ready);
        end
        step();
        checks++;
        if (dout !== (8'h01 ^ INV) || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL prio_scan got data=%h done=%b busy=%b exp %h 0 1",
                     dout, done, busy, 8'h01 ^ INV);
        end
        scan  = 1'b0;
        valid = 1'b0;
        step();
        checks++;
        if (dout !== INV || done !== 1'b0) begin
            failures++;
            $display("FAIL prio_exit got data=%h done=%b exp %h 0", dout, done, INV);
        end
        // Start a hold, then raise scan: it must be ignored until the done cycle.
        valid = 1'b1;
        din   = 3'd2;
        step();
        valid = 1'b0;
        scan  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dout !== (8'h04 ^ INV)) begin
                failures++;
                $display("FAIL hold_ignores_scan cyc%0d got=%h exp=%h", i, dout, 8'h04 ^ INV);
            end
        end
        step();
        checks++;
        if (dout !== INV || done !== 1'b1) begin
            failures++;
            $display("FAIL hold_scan_done got data=%h done=%b exp %h 1", dout, done, INV);
        end
        step();
        checks++;
        if (dout !== (8'h01 ^ INV) || busy !== 1'b1) begin
            failures++;
            $display("FAIL scan_after_hold got data=%h busy=%b exp %h 1", dout, busy, 8'h01 ^ INV);
        end
        scan = 1'b0;
        step();
    endtask

    task automatic test_abort();
        valid = 1'b1;
        din   = 3'd6;
        step();
        valid = 1'b0;
        step();
        checks++;
        if (dout !== (8'h40 ^ INV)) begin
            failures++;
            $display("FAIL abort_pre got=%h exp=%h", dout, 8'h40 ^ INV);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (dout !== INV || done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_en cyc%0d got data=%h done=%b busy=%b exp %h 0 0",
                         i, dout, done, busy, INV);
            end
        end
        en = 1'b1;
        // After abort a new accept must still work with a full hold.
        valid = 1'b1;
        din   = 3'd1;
        step();
        valid = 1'b0;
        checks++;
        if (dout !== (8'h02 ^ INV)) begin
            failures++;
            $display("FAIL abort_recover got=%h exp=%h", dout, 8'h02 ^ INV);
        end
        repeat (5) step();
        scan = 1'b1;
        repeat (3) step();
        checks++;
        if (dout !== (8'h02 ^ INV)) begin
            failures++;
            $display("FAIL reset_midscan_pre got=%h exp=%h", dout, 8'h02 ^ INV);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== INV || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got data=%h busy=%b done=%b exp %h 0 0",
                     dout, busy, done, INV);
        end
        scan = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (dout !== INV || ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got data=%h ready=%b exp %h 1", dout, ready, INV);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_scan();
        test_scan_priority();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
